// File: rtl/uart_pkg.sv
// Shared encodings for the parametrised UART core: parity modes, FSM states
// and the data-width base that cfg_data_bits is added to.
package uart_pkg;

  localparam int DATA_BITS_BASE = 5;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Reserved mode 3 behaves as no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample-tick prescaler: counts max(div,1)-1 down to 0, ticks at 0 and
// reloads. The divisor is captured on load so a frame keeps its own rate.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] reload;

  always_comb begin
    div_d  = load ? div : div_q;
    reload = (div_d == '0) ? '0 : div_d - 1'b1;
    if (load || cnt_q == '0) cnt_d = reload;
    else                     cnt_d = cnt_q - 1'b1;
  end

  assign tick = !load && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Parametrised UART: runtime divisor, 5-8 data bits, optional parity, 1/2 stop
// bits on TX, oversampled 3-sample majority receive with per-frame errors.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             tx,
  output logic             tx_busy,
  input  logic             rx,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SMP_A     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] SMP_B     = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] SMP_C     = TW'(OVERSAMPLE / 2 + 1);

  // ---------------- transmitter ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [7:0]    tx_shreg_q, tx_shreg_d, tx_mask;
  logic [2:0]    tx_bit_q, tx_bit_d, tx_last_q, tx_last_d;
  logic [1:0]    tx_par_q, tx_par_d;
  logic          tx_par_bit_q, tx_par_bit_d;
  logic          tx_stop2_q, tx_stop2_d, tx_stop_cnt_q, tx_stop_cnt_d;
  logic [TW-1:0] tx_tcnt_q, tx_tcnt_d;
  logic          tx_q, tx_d, tx_ready_q, tx_ready_d, tx_busy_q, tx_busy_d;
  logic          tx_load, tx_tick, tx_bit_done;

  uart_baud_gen #(.DIV_W(DIV_W)) u_tx_baud (
    .clk(clk), .rst(rst), .load(tx_load), .div(baud_div), .tick(tx_tick)
  );

  assign tx_bit_done = tx_tick && (tx_tcnt_q == TICK_LAST);

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_shreg_d    = tx_shreg_q;
    tx_bit_d      = tx_bit_q;
    tx_last_d     = tx_last_q;
    tx_par_d      = tx_par_q;
    tx_par_bit_d  = tx_par_bit_q;
    tx_stop2_d    = tx_stop2_q;
    tx_stop_cnt_d = tx_stop_cnt_q;
    tx_tcnt_d     = tx_tcnt_q;
    tx_d          = tx_q;
    tx_load       = 1'b0;
    tx_mask       = 8'hFF >> (2'd3 - cfg_data_bits);
    if (tx_tick) tx_tcnt_d = tx_bit_done ? '0 : tx_tcnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: if (tx_valid) begin
        tx_load       = 1'b1;
        tx_tcnt_d     = '0;
        tx_shreg_d    = tx_data & tx_mask;
        tx_last_d     = 3'(DATA_BITS_BASE - 1) + 3'(cfg_data_bits);
        tx_par_d      = cfg_parity;
        tx_par_bit_d  = (^(tx_data & tx_mask)) ^ (cfg_parity == PAR_ODD);
        tx_stop2_d    = cfg_stop2;
        tx_stop_cnt_d = 1'b0;
        tx_state_d    = TX_START;
        tx_d          = 1'b0;
      end
      TX_START: if (tx_bit_done) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shreg_q[0];
        tx_shreg_d = tx_shreg_q >> 1;
      end
      TX_DATA: if (tx_bit_done) begin
        if (tx_bit_q != tx_last_q) begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_d       = tx_shreg_q[0];
          tx_shreg_d = tx_shreg_q >> 1;
        end else if (parity_on(tx_par_q)) begin
          tx_state_d = TX_PARITY;
          tx_d       = tx_par_bit_q;
        end else begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
      end
      TX_PARITY: if (tx_bit_done) begin
        tx_state_d = TX_STOP;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_bit_done) begin
        if (tx_stop2_q && !tx_stop_cnt_q) tx_stop_cnt_d = 1'b1;
        else                              tx_state_d    = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE);
    tx_busy_d  = (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q    <= TX_IDLE;
      tx_shreg_q    <= '0;
      tx_bit_q      <= '0;
      tx_last_q     <= '0;
      tx_par_q      <= PAR_NONE;
      tx_par_bit_q  <= 1'b0;
      tx_stop2_q    <= 1'b0;
      tx_stop_cnt_q <= 1'b0;
      tx_tcnt_q     <= '0;
      tx_q          <= 1'b1;
      tx_ready_q    <= 1'b1;
      tx_busy_q     <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_shreg_q    <= tx_shreg_d;
      tx_bit_q      <= tx_bit_d;
      tx_last_q     <= tx_last_d;
      tx_par_q      <= tx_par_d;
      tx_par_bit_q  <= tx_par_bit_d;
      tx_stop2_q    <= tx_stop2_d;
      tx_stop_cnt_q <= tx_stop_cnt_d;
      tx_tcnt_q     <= tx_tcnt_d;
      tx_q          <= tx_d;
      tx_ready_q    <= tx_ready_d;
      tx_busy_q     <= tx_busy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

  // ---------------- receiver ----------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [TW-1:0] rx_tcnt_q, rx_tcnt_d;
  logic [1:0]    rx_smp_q, rx_smp_d, rx_cfg_q, rx_cfg_d, rx_par_q, rx_par_d;
  logic [7:0]    rx_shreg_q, rx_shreg_d, rx_data_q, rx_data_d;
  logic [2:0]    rx_bit_q, rx_bit_d, rx_last_q, rx_last_d;
  logic          rx_acc_q, rx_acc_d, rx_perr_q, rx_perr_d, rx_arm_q, rx_arm_d;
  logic          rx_valid_q, rx_valid_d, rx_perr_out_q, rx_perr_out_d;
  logic          rx_ferr_q, rx_ferr_d, rx_busy_q, rx_busy_d;
  logic          rx_s, rx_maj, rx_load, rx_tick, rx_decide;

  uart_baud_gen #(.DIV_W(DIV_W)) u_rx_baud (
    .clk(clk), .rst(rst), .load(rx_load), .div(baud_div), .tick(rx_tick)
  );

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign rx_maj    = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s) | (rx_smp_q[1] & rx_s);
  assign rx_decide = rx_tick && (rx_tcnt_q == SMP_C);

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], rx};
    rx_state_d    = rx_state_q;
    rx_tcnt_d     = rx_tcnt_q;
    rx_smp_d      = rx_smp_q;
    rx_cfg_d      = rx_cfg_q;
    rx_par_d      = rx_par_q;
    rx_shreg_d    = rx_shreg_q;
    rx_bit_d      = rx_bit_q;
    rx_last_d     = rx_last_q;
    rx_acc_d      = rx_acc_q;
    rx_perr_d     = rx_perr_q;
    rx_arm_d      = rx_arm_q;
    rx_data_d     = rx_data_q;
    rx_perr_out_d = rx_perr_out_q;
    rx_ferr_d     = rx_ferr_q;
    rx_valid_d    = 1'b0;
    rx_load       = 1'b0;
    if (rx_tick) begin
      rx_tcnt_d = (rx_tcnt_q == TICK_LAST) ? '0 : rx_tcnt_q + 1'b1;
      if (rx_tcnt_q == SMP_A) rx_smp_d[0] = rx_s;
      if (rx_tcnt_q == SMP_B) rx_smp_d[1] = rx_s;
    end
    case (rx_state_q)
      // After a frame error the line must return high before a new start.
      RX_IDLE: begin
        if (rx_s) rx_arm_d = 1'b1;
        if (rx_arm_q && !rx_s) begin
          rx_load    = 1'b1;
          rx_tcnt_d  = '0;
          rx_cfg_d   = cfg_data_bits;
          rx_last_d  = 3'(DATA_BITS_BASE - 1) + 3'(cfg_data_bits);
          rx_par_d   = cfg_parity;
          rx_acc_d   = 1'b0;
          rx_perr_d  = 1'b0;
          rx_state_d = RX_START;
        end
      end
      RX_START: if (rx_decide) begin
        rx_state_d = rx_maj ? RX_IDLE : RX_DATA;
        rx_bit_d   = '0;
      end
      RX_DATA: if (rx_decide) begin
        rx_shreg_d = {rx_maj, rx_shreg_q[7:1]};
        rx_acc_d   = rx_acc_q ^ rx_maj;
        if (rx_bit_q != rx_last_q)  rx_bit_d   = rx_bit_q + 3'd1;
        else if (parity_on(rx_par_q)) rx_state_d = RX_PARITY;
        else                          rx_state_d = RX_STOP;
      end
      RX_PARITY: if (rx_decide) begin
        rx_perr_d  = rx_maj ^ rx_acc_q ^ (rx_par_q == PAR_ODD);
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_decide) begin
        rx_valid_d    = 1'b1;
        rx_data_d     = rx_shreg_q >> (2'd3 - rx_cfg_q);
        rx_perr_out_d = rx_perr_q;
        rx_ferr_d     = !rx_maj;
        rx_arm_d      = rx_maj;
        rx_state_d    = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    rx_busy_d = (rx_state_d != RX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '1;
      rx_state_q    <= RX_IDLE;
      rx_tcnt_q     <= '0;
      rx_smp_q      <= '1;
      rx_cfg_q      <= '0;
      rx_par_q      <= PAR_NONE;
      rx_shreg_q    <= '0;
      rx_bit_q      <= '0;
      rx_last_q     <= '0;
      rx_acc_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_arm_q      <= 1'b1;
      rx_data_q     <= '0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      rx_state_q    <= rx_state_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_smp_q      <= rx_smp_d;
      rx_cfg_q      <= rx_cfg_d;
      rx_par_q      <= rx_par_d;
      rx_shreg_q    <= rx_shreg_d;
      rx_bit_q      <= rx_bit_d;
      rx_last_q     <= rx_last_d;
      rx_acc_q      <= rx_acc_d;
      rx_perr_q     <= rx_perr_d;
      rx_arm_q      <= rx_arm_d;
      rx_data_q     <= rx_data_d;
      rx_perr_out_q <= rx_perr_out_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_valid_q    <= rx_valid_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised successor to the team's fixed-format mini UART.
- Adds runtime baud divisor, 5–8 data bits, none/even/odd parity, 1/2 stop bits, and N-times oversampling with 3-sample majority vote.
- Uses ready/valid transmit handshake and reports receive errors per frame.
- Sits between the serial pins and a register/bus wrapper; one instance per serial channel.

Parameters:
OVERSAMPLE, 16, oversample ticks per bit; even, >=8
DIV_W, 16, width of baud_div input
SYNC_STAGES, 2, rx input synchroniser depth (>=2)

Ports:
clk  in  1  master clock
rst  in  1  reset
baud_div  in  DIV_W  clocks per oversample tick; 0 treated as 1
cfg_data_bits  in  2  data bits = 5 + value
cfg_parity  in  2  0 none, 1 even, 2 odd, 3 reserved (= none)
cfg_stop2  in  1  1 = two stop bits (TX only)
tx_valid  in  1  byte offered
tx_ready  out  1  core accepts byte this cycle
tx_data  in  8  byte to send, LSB first; unused upper bits ignored
tx  out  1  serial out, idle high
tx_busy  out  1  frame in progress
rx  in  1  serial in, asynchronous
rx_valid  out  1  one-cycle pulse: frame complete
rx_data  out  8  received byte, unused upper bits zero
rx_parity_err  out  1  qualified by rx_valid
rx_frame_err  out  1  qualified by rx_valid: stop bit sampled low
rx_busy  out  1  receiver not idle

Behaviour:
Clock and reset:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, both error flags 0, rx_busy=0, both FSMs IDLE, synchroniser flops all 1.
- Reset asserted mid-frame aborts immediately; tx returns high on the next edge.

Baud prescalers:
- TX and RX each have an independent prescaler that counts max(baud_div,1)-1 down to 0, emits a one-clock tick at 0, then reloads.
- Bit period = max(baud_div,1)*OVERSAMPLE clocks.
- Config (baud_div, data bits, parity, stop) is latched at frame start; mid-frame changes have no effect on the current frame.

TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- tx_ready=1 only in IDLE. Transfer occurs when tx_valid && tx_ready.
- On transfer: tx goes low on the next edge, the prescaler and tick count restart, tx_ready drops.
- Each bit lasts OVERSAMPLE ticks. Data is sent LSB first, cfg_data_bits+5 bits.
- Parity bit: XOR of the sent data bits (even); inverted for odd.
- STOP drives high for 1 or 2 bit periods, then IDLE. tx_ready rises the cycle after the last stop tick.
- Back-to-back: with tx_valid held high, the next start bit begins exactly one clock after tx_ready rises.

RX path:
- rx passes through SYNC_STAGES flops.
- IDLE: a synchronised low restarts the RX prescaler and the tick counter, then goes to START.
- Each bit samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; the bit value is the 2-of-3 majority, decided at tick OVERSAMPLE/2+1.
- START: majority high = glitch; return to IDLE with no rx_valid and no error. Otherwise continue.
- DATA: shift in LSB first, then PARITY if enabled, then STOP.
- Only the first stop bit is checked. At the decision point of the stop bit:
  - rx_valid pulses for 1 clock;
  - rx_data, rx_parity_err and rx_frame_err update in the same cycle and hold until the next rx_valid;
  - the FSM returns to IDLE immediately, so the next start edge is accepted during the remainder of the stop bit.
- Break (line low for the whole frame): rx_data=0, rx_frame_err=1. The receiver then waits in IDLE for the line to go high before re-arming (edge, not level, detection after a frame error).
- rx_busy=1 in every state except IDLE.

Decomposition:
Package uart_pkg holds:
- parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD);
- TX and RX state enumerations;
- the DATA_BITS_BASE=5 constant.

Sub-module uart_baud_gen (DIV_W): load, div, tick. Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset: rst high 3 clocks mid-TX frame -> tx=1, tx_ready=1, rx_valid=0 on the first edge after reset.
- TX 8N1: baud_div=4, OVERSAMPLE=16, send 0xA5 -> tx low for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, high 64 clocks; tx_ready high at clock 641 after transfer.
- TX 7E2: send 0x53 (7 bits, 4 ones) -> parity bit 0, two 64-clock stop bits, total frame 11 bits.
- Loopback tx->rx: 8O1 with 0x00, 0xFF, 0x3C sent back-to-back -> three rx_valid pulses; data matches; both error flags 0.
- RX glitch and errors: 20-clock low pulse -> no rx_valid. A frame with a flipped parity bit -> rx_parity_err=1. A low stop bit -> rx_frame_err=1.
- Majority vote: a single-tick inverted spike centred on each data-bit sample point -> data still received correctly.
